mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: tile sequencer for the MAC array.
// Loads IC0 weight rows, waits for the array to settle, streams num_ox ifmap/psum
// beats and collects the matching accum_out beats, stalling the whole array
// whenever a result is at the head of the valid-tag pipe but cannot be accepted.
module mac_seq_ctrl #(
    parameter int IC0     = 4,
    parameter int OC0     = 4,
    parameter int NOX_W   = 7,
    parameter int OUT_LAT = IC0 + OC0,
    parameter int WL_LAT  = IC0 + OC0 - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NOX_W-1:0] num_ox,
    output logic             busy,
    output logic             done,
    input  logic             weight_valid,
    output logic             weight_ready,
    input  logic             ifmap_valid,
    output logic             ifmap_ready,
    input  logic             psum_valid,
    output logic             psum_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             en,
    output logic             en_weight00,
    output logic             weight_fifo_enq,
    output logic             ifmap_fifo_enq,
    output logic             accum_in_fifo_enq,
    output logic             accum_out_fifo_enq
);

    localparam int WC_W = (IC0 > 1) ? $clog2(IC0) : 1;
    localparam int SC_W = (WL_LAT > 1) ? $clog2(WL_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        WSETTLE,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NOX_W-1:0]   num_ox_q;
    logic [NOX_W-1:0]   fire_cnt;
    logic [NOX_W-1:0]   out_cnt;
    logic [WC_W-1:0]    wrow_cnt;
    logic [SC_W-1:0]    settle_cnt;
    logic [OUT_LAT-1:0] tag;
    logic               head;
    logic               blocked;
    logic               fire;
    logic               last_wrow;
    logic               last_settle;

    assign head        = tag[OUT_LAT-1];
    assign blocked     = head & ~out_ready;
    assign last_wrow   = (wrow_cnt == WC_W'(IC0 - 1));
    assign last_settle = (settle_cnt == SC_W'(WL_LAT - 1));

    // Next-state and output decode; every output is forced low while rst_n is low.
    always_comb begin
        state_nxt          = state;
        busy               = 1'b0;
        done               = 1'b0;
        weight_ready       = 1'b0;
        ifmap_ready        = 1'b0;
        psum_ready         = 1'b0;
        out_valid          = 1'b0;
        en                 = 1'b0;
        en_weight00        = 1'b0;
        weight_fifo_enq    = 1'b0;
        ifmap_fifo_enq     = 1'b0;
        accum_in_fifo_enq  = 1'b0;
        accum_out_fifo_enq = 1'b0;
        fire               = 1'b0;
        if (rst_n) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (num_ox == '0) ? DONE : WLOAD;
                    end
                end
                WLOAD: begin
                    weight_ready    = 1'b1;
                    en              = weight_valid;
                    en_weight00     = weight_valid;
                    weight_fifo_enq = weight_valid;
                    if (weight_valid && last_wrow) begin
                        state_nxt = WSETTLE;
                    end
                end
                WSETTLE: begin
                    en = 1'b1;
                    if (last_settle) begin
                        state_nxt = STREAM;
                    end
                end
                STREAM: begin
                    en                 = ~blocked;
                    fire               = ifmap_valid & psum_valid & ~blocked;
                    ifmap_ready        = fire;
                    psum_ready         = fire;
                    ifmap_fifo_enq     = fire;
                    accum_in_fifo_enq  = fire;
                    out_valid          = head;
                    accum_out_fifo_enq = head & out_ready;
                    if (fire && ((fire_cnt + NOX_W'(1)) == num_ox_q)) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    en                 = ~blocked;
                    out_valid          = head;
                    accum_out_fifo_enq = head & out_ready;
                    if (accum_out_fifo_enq && ((out_cnt + NOX_W'(1)) == num_ox_q)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register plus tile counters and the valid-tag pipe that tracks in-flight beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            num_ox_q   <= '0;
            fire_cnt   <= '0;
            out_cnt    <= '0;
            wrow_cnt   <= '0;
            settle_cnt <= '0;
            tag        <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                num_ox_q <= num_ox;
            end
            if (state == DONE) begin
                fire_cnt   <= '0;
                out_cnt    <= '0;
                wrow_cnt   <= '0;
                settle_cnt <= '0;
                tag        <= '0;
            end else begin
                if (state == WLOAD && weight_valid) begin
                    wrow_cnt <= last_wrow ? '0 : wrow_cnt + WC_W'(1);
                end
                if (state == WSETTLE) begin
                    settle_cnt <= last_settle ? '0 : settle_cnt + SC_W'(1);
                end
                if (fire) begin
                    fire_cnt <= fire_cnt + NOX_W'(1);
                end
                if (accum_out_fifo_enq) begin
                    out_cnt <= out_cnt + NOX_W'(1);
                end
                if (en) begin
                    tag <= {tag[OUT_LAT-2:0], fire};
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench for mac_seq_ctrl.
// A driver steps a behavioural model (remaining-work counters plus a beat queue)
// and queues the expected control outputs per cycle and the expected beat order;
// a monitor pops and compares against what the DUT presents.
module tb_mac_seq_ctrl;

    localparam int IC0     = 4;
    localparam int OC0     = 4;
    localparam int NOX_W   = 7;
    localparam int OUT_LAT = IC0 + OC0;
    localparam int WL_LAT  = IC0 + OC0 - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [NOX_W-1:0] num_ox;
    logic             busy;
    logic             done;
    logic             weight_valid;
    logic             weight_ready;
    logic             ifmap_valid;
    logic             ifmap_ready;
    logic             psum_valid;
    logic             psum_ready;
    logic             out_valid;
    logic             out_ready;
    logic             en;
    logic             en_weight00;
    logic             weight_fifo_enq;
    logic             ifmap_fifo_enq;
    logic             accum_in_fifo_enq;
    logic             accum_out_fifo_enq;

    mac_seq_ctrl #(
        .IC0(IC0), .OC0(OC0), .NOX_W(NOX_W), .OUT_LAT(OUT_LAT), .WL_LAT(WL_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_ox(num_ox),
        .busy(busy), .done(done),
        .weight_valid(weight_valid), .weight_ready(weight_ready),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .en(en), .en_weight00(en_weight00), .weight_fifo_enq(weight_fifo_enq),
        .ifmap_fifo_enq(ifmap_fifo_enq), .accum_in_fifo_enq(accum_in_fifo_enq),
        .accum_out_fifo_enq(accum_out_fifo_enq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] exp_q[$];
    int          beat_q[$];

    int m_active     = 0;
    int m_done_pend  = 0;
    int m_wrows      = 0;
    int m_settle     = 0;
    int m_fires_left = 0;
    int m_outs_left  = 0;
    int m_fire_idx   = 0;
    bit pipe[$];

    int mon_cyc        = 0;
    int beats_seen     = 0;
    int first_fire_cyc = -1;
    int first_out_cyc  = -1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic pipeClear();
        pipe.delete();
        for (int i = 0; i < OUT_LAT; i++) pipe.push_back(1'b0);
    endtask

    function automatic bit inStream();
        return (m_active != 0) && (m_done_pend == 0) && (m_wrows == 0) &&
               (m_settle == 0) && (m_fires_left > 0);
    endfunction

    // Behavioural model: one call per clock cycle, using the inputs just driven.
    task automatic modelStep(output logic [11:0] e);
        bit b_busy, b_done, b_wrdy, b_ov, b_en, b_w, b_fire, b_oenq, hd, blk;
        b_busy = 0; b_done = 0; b_wrdy = 0; b_ov = 0; b_en = 0;
        b_w = 0; b_fire = 0; b_oenq = 0;
        if (!rst_n) begin
            m_active = 0; m_done_pend = 0;
            pipeClear();
            beat_q.delete();
        end else if (m_done_pend != 0) begin
            b_busy = 1; b_done = 1;
            m_done_pend = 0; m_active = 0;
            pipeClear();
        end else if (m_active == 0) begin
            if (start) begin
                if (num_ox == 0) begin
                    m_done_pend = 1;
                end else begin
                    m_active = 1; m_wrows = IC0; m_settle = WL_LAT;
                    m_fires_left = int'(num_ox); m_outs_left = int'(num_ox);
                    m_fire_idx = 0;
                end
            end
        end else begin
            b_busy = 1;
            hd  = pipe[0];
            blk = hd && !out_ready;
            if (m_wrows > 0) begin
                b_wrdy = 1; b_en = weight_valid; b_w = weight_valid;
                if (weight_valid) m_wrows--;
            end else if (m_settle > 0) begin
                b_en = 1;
                m_settle--;
            end else begin
                b_en   = !blk;
                b_ov   = hd;
                b_oenq = hd && out_ready;
                if (m_fires_left > 0) begin
                    b_fire = ifmap_valid && psum_valid && !blk;
                    if (b_fire) begin
                        m_fires_left--;
                        beat_q.push_back(m_fire_idx);
                        m_fire_idx++;
                    end
                end
                if (b_oenq) begin
                    m_outs_left--;
                    if (m_outs_left == 0) m_done_pend = 1;
                end
            end
            if (b_en) begin
                void'(pipe.pop_front());
                pipe.push_back(b_fire);
            end
        end
        e = {b_busy, b_done, b_wrdy, b_fire, b_fire, b_ov, b_en, b_w, b_w, b_fire, b_fire, b_oenq};
    endtask

    task automatic applyStimulus(input bit r, input bit st, input logic [NOX_W-1:0] n,
                                 input bit wv, input bit iv, input bit pv, input bit ordy);
        logic [11:0] e;
        @(negedge clk);
        rst_n = r; start = st; num_ox = n;
        weight_valid = wv; ifmap_valid = iv; psum_valid = pv; out_ready = ordy;
        modelStep(e);
        exp_q.push_back(e);
    endtask

    // Modes: 0 nominal, 1 ifmap bubbles, 2 five-cycle backpressure, 3 random,
    // 4 start pulses while busy, 5 reset after three fires.
    task automatic runTile(input int num, input int mode);
        bit finished = 0;
        bit tog = 1;
        bit bp_used = 0;
        int bp_left = 0;
        bit st, wv, iv, pv, ordy;
        logic [NOX_W-1:0] n;
        if (mode == 3) applyStimulus(1, 1, NOX_W'(num), 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        else applyStimulus(1, 1, NOX_W'(num), 1, 1, 1, 1);
        for (int c = 0; c < 2000; c++) begin
            if (m_active == 0 && m_done_pend == 0) begin
                finished = 1;
                break;
            end
            if (mode == 5 && inStream() && (num - m_fires_left) == 3) begin
                applyStimulus(0, 0, '0, 1, 1, 1, 1);
                finished = 1;
                break;
            end
            st = 0; n = NOX_W'(num); wv = 1; iv = 1; pv = 1; ordy = 1;
            case (mode)
                1: begin
                    if (inStream()) begin
                        iv  = tog;
                        tog = ~tog;
                    end
                end
                2: begin
                    if (!bp_used && pipe[0] && m_wrows == 0 && m_settle == 0) begin
                        bp_used = 1;
                        bp_left = 5;
                    end
                    if (bp_left > 0) begin
                        ordy = 0;
                        bp_left--;
                    end
                end
                3: begin
                    wv   = 1'($urandom_range(0, 1));
                    iv   = ($urandom_range(0, 3) != 0);
                    pv   = ($urandom_range(0, 3) != 0);
                    ordy = ($urandom_range(0, 3) != 0);
                    st   = ($urandom_range(0, 7) == 0);
                    n    = NOX_W'($urandom_range(0, 20));
                end
                4: begin
                    st = ((c % 5) == 2);
                    n  = NOX_W'(c + 3);
                end
                default: ;
            endcase
            applyStimulus(1, st, n, wv, iv, pv, ordy);
        end
        checkOutput($sformatf("tile_completes(num=%0d,mode=%0d)", num, mode), 32'(finished), 32'd1);
    endtask

    // Monitor: compares each cycle's outputs and the order of accepted accum_out beats.
    initial begin
        logic [11:0] e;
        logic [11:0] a;
        forever begin
            @(negedge clk);
            #2;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {busy, done, weight_ready, ifmap_ready, psum_ready, out_valid, en,
                     en_weight00, weight_fifo_enq, ifmap_fifo_enq, accum_in_fifo_enq,
                     accum_out_fifo_enq};
                checkOutput($sformatf("ctrl_outputs@%0d", mon_cyc), 32'(a), 32'(e));
                if (ifmap_fifo_enq && first_fire_cyc < 0) first_fire_cyc = mon_cyc;
                if (out_valid && first_out_cyc < 0) first_out_cyc = mon_cyc;
                if (accum_out_fifo_enq) begin
                    if (beat_q.size() == 0) begin
                        checkOutput("unexpected_beat", 32'(beats_seen), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("beat_order", 32'(beats_seen), 32'(beat_q.pop_front()));
                    end
                    beats_seen++;
                end
                if (!rst_n || done) beats_seen = 0;
            end
        end
    end

    // Directed scenarios followed by a batch of randomized tiles.
    initial begin
        rst_n = 0; start = 0; num_ox = '0;
        weight_valid = 0; ifmap_valid = 0; psum_valid = 0; out_ready = 0;
        pipeClear();
        applyStimulus(0, 0, '0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7'd5, 1, 1, 1, 1);

        $display("[TB] nominal tile, num_ox=8");
        first_fire_cyc = -1;
        first_out_cyc  = -1;
        runTile(8, 0);
        checkOutput("first_out_latency", 32'(first_out_cyc - first_fire_cyc), 32'(OUT_LAT));

        $display("[TB] ifmap bubbles, num_ox=4");
        runTile(4, 1);

        $display("[TB] backpressure, num_ox=8");
        runTile(8, 2);

        $display("[TB] zero-length tile");
        runTile(0, 3);
        runTile(0, 0);

        $display("[TB] reset mid-stream, then num_ox=2");
        runTile(8, 5);
        runTile(2, 0);

        $display("[TB] start pulses while busy, num_ox=6");
        runTile(6, 4);

        $display("[TB] maximum num_ox");
        runTile(127, 0);

        $display("[TB] randomized tiles");
        for (int t = 0; t < 20; t++) begin
            runTile($urandom_range(1, 12), 3);
            if ($urandom_range(0, 1) == 1) applyStimulus(1, 0, '0, 1, 1, 1, 1);
        end

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 0, 0, 0, 1);
        #3;
        checkOutput("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        checkOutput("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
